fib_seq_gen: RTL

Parametrised Fibonacci sequence generator with a valid/ready output stream, programmable upper limit, stop-or-wrap mode and overflow detection. It is the general-width successor to the team's fixed 4-bit free-running Fibonacci counter. It feeds downstream test-pattern consumers that may apply backpressure.

---
 rtl/fib_pkg.sv | 13 +
 rtl/fib_seq_gen_if.sv | 15 +
 rtl/fib_step.sv | 13 +
 rtl/fib_seq_gen.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci sequence generator.
package fib_pkg;

  localparam int FIB_WIDTH_DEF = 16;
  localparam int FIB_IDX_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Valid/ready output stream carrying one Fibonacci term and its index.
interface fib_seq_gen_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
) ();

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic [IDX_W-1:0] out_index;

  modport master (output out_valid, output out_value, output out_index, input out_ready);
  modport slave  (input out_valid, input out_value, input out_index, output out_ready);

endinterface

// File: rtl/fib_step.sv
// Combinational WIDTH-bit adder with carry-out, used to form the next term.
module fib_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: streams F(0),F(1),... up to a programmable limit,
// then stops or wraps, flagging when the next term no longer fits in WIDTH bits.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int IDX_W = FIB_IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_mode,
  fib_seq_gen_if.master    out,
  output logic             done,
  output logic             overflow,
  output logic             wrapped,
  output logic             busy
);

  fib_state_t       state, state_d;
  logic [WIDTH-1:0] cur, cur_d;
  logic [WIDTH-1:0] nxt, nxt_d;
  logic             nxt_ovf, nxt_ovf_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             wrap_q, wrap_d;
  logic             overflow_d, wrapped_d;
  logic             valid_q;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             xfer, seq_end;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a     (cur),
    .b     (nxt),
    .sum   (sum),
    .carry (carry)
  );

  assign xfer    = valid_q & out.out_ready;
  assign seq_end = (nxt > limit_q) | nxt_ovf;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state;
    cur_d      = cur;
    nxt_d      = nxt;
    nxt_ovf_d  = nxt_ovf;
    idx_d      = idx;
    limit_d    = limit_q;
    wrap_d     = wrap_q;
    overflow_d = overflow;
    wrapped_d  = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          limit_d    = limit;
          wrap_d     = wrap_mode;
          cur_d      = '0;
          nxt_d      = WIDTH'(1);
          idx_d      = '0;
          nxt_ovf_d  = 1'b0;
          overflow_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (seq_end) begin
            overflow_d = overflow | nxt_ovf;
            if (wrap_q) begin
              cur_d     = '0;
              nxt_d     = WIDTH'(1);
              idx_d     = '0;
              nxt_ovf_d = 1'b0;
              wrapped_d = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            cur_d     = nxt;
            nxt_d     = sum;
            nxt_ovf_d = carry;
            idx_d     = idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      nxt      <= WIDTH'(1);
      nxt_ovf  <= 1'b0;
      idx      <= '0;
      limit_q  <= '0;
      wrap_q   <= 1'b0;
      overflow <= 1'b0;
      wrapped  <= 1'b0;
      valid_q  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cur      <= cur_d;
      nxt      <= nxt_d;
      nxt_ovf  <= nxt_ovf_d;
      idx      <= idx_d;
      limit_q  <= limit_d;
      wrap_q   <= wrap_d;
      overflow <= overflow_d;
      wrapped  <= wrapped_d;
      // Status flags are registered from the next state so they change on the same edge.
      valid_q  <= (state_d == RUN);
      done     <= (state_d == DONE);
      busy     <= (state_d == RUN);
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_value = cur;
  assign out.out_index = idx;

endmodule
